// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor sequencer.
// Computes diff = a - b one bit per clock, LSB first, through a single
// full-subtractor slice with a registered borrow. start/busy/done handshake.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bo_q, bo_d;

    logic               x, y, dbit, br_next;

    // One subtractor slice on the current LSBs of the operand shift registers.
    always_comb begin
        x       = a_sr_q[0];
        y       = b_sr_q[0];
        dbit    = x ^ y ^ br_q;
        br_next = (~x & y) | (~(x ^ y) & br_q);
    end

    // Sequencer next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = 1'b0;
                    diff_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Difference bits enter at the MSB so bit i lands at diff[i]
                // after WIDTH shifts; shift form keeps WIDTH=1 legal.
                diff_d            = diff_q >> 1;
                diff_d[WIDTH-1]   = dbit;
                a_sr_d            = a_sr_q >> 1;
                b_sr_d            = b_sr_q >> 1;
                br_d              = br_next;
                cnt_d             = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bo_d    = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bo   = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st8 = 1'b0, st1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy8, done8, bo8, busy1, done1, bo1;
    logic [7:0] diff8;
    logic [0:0] diff1;

    int vectors = 0;
    int miscompares = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bo(bo8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bo(bo1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected diff: idle holds the last result; after k shifts the top k bits
    // carry the low k bits of (a-b) mod 2^w.
    function automatic longint exp_diff(input int p, input int w, input longint a,
                                        input longint b, input longint hold);
        longint mask, res;
        int k;
        if (p == 0) return hold;
        k    = p - 1;
        mask = (longint'(1) << w) - 1;
        res  = (a - b) & mask;
        return (res & ((longint'(1) << k) - 1)) << (w - k);
    endfunction

    // Operation model: phase 0 idle, 1..W run, W+1 done.
    int     m8_p = 0, m1_p = 0;
    longint m8_a = 0, m8_b = 0, m8_hd = 0, m1_a = 0, m1_b = 0, m1_hd = 0;
    logic   m8_hb = 1'b0, m1_hb = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_p <= 0; m8_a <= 0; m8_b <= 0; m8_hd <= 0; m8_hb <= 1'b0;
        end else if (m8_p == 0) begin
            if (st8) begin m8_p <= 1; m8_a <= longint'(a8); m8_b <= longint'(b8); end
        end else if (m8_p == 8) begin
            m8_p <= 9; m8_hd <= exp_diff(9, 8, m8_a, m8_b, 0); m8_hb <= (m8_a < m8_b);
        end else if (m8_p == 9) begin
            m8_p <= 0;
        end else begin
            m8_p <= m8_p + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_p <= 0; m1_a <= 0; m1_b <= 0; m1_hd <= 0; m1_hb <= 1'b0;
        end else if (m1_p == 0) begin
            if (st1) begin m1_p <= 1; m1_a <= longint'(a1); m1_b <= longint'(b1); end
        end else if (m1_p == 1) begin
            m1_p <= 2; m1_hd <= exp_diff(2, 1, m1_a, m1_b, 0); m1_hb <= (m1_a < m1_b);
        end else begin
            m1_p <= 0;
        end
    end

    // Every cycle: DUT outputs against the model, sampled mid-cycle.
    always @(negedge clk) begin
        chk("busy8", longint'(busy8), longint'(m8_p >= 1 && m8_p <= 8));
        chk("done8", longint'(done8), longint'(m8_p == 9));
        chk("diff8", longint'(diff8), exp_diff(m8_p, 8, m8_a, m8_b, m8_hd));
        chk("bo8",   longint'(bo8),   longint'(m8_hb));
        chk("busy1", longint'(busy1), longint'(m1_p == 1));
        chk("done1", longint'(done1), longint'(m1_p == 2));
        chk("diff1", longint'(diff1), exp_diff(m1_p, 1, m1_a, m1_b, m1_hd));
        chk("bo1",   longint'(bo1),   longint'(m1_hb));
    end

    // Called just after a negedge with dut8 idle; returns in the DONE cycle.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input bit hold,
                       input logic [7:0] ed, input logic eb, input string nm);
        int n = 0;
        st8 = 1'b1; a8 = ta; b8 = tb;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (hold) begin st8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
            else begin st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
            if (done8) break;
        end
        chk({nm, "_lat"},  longint'(n), 9);
        chk({nm, "_diff"}, longint'(diff8), longint'(ed));
        chk({nm, "_bo"},   longint'(bo8), longint'(eb));
    endtask

    task automatic op1(input logic ta, input logic tb, input logic ed, input logic eb,
                       input string nm);
        int n = 0;
        st1 = 1'b1; a1 = ta; b1 = tb;
        while (n < 6) begin
            @(negedge clk);
            n++;
            st1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
            if (done1) break;
        end
        chk({nm, "_lat"},  longint'(n), 2);
        chk({nm, "_diff"}, longint'(diff1), longint'(ed));
        chk({nm, "_bo"},   longint'(bo1), longint'(eb));
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", longint'(busy8), 0);
        chk("rst_diff", longint'(diff8), 0);
        rst_n = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "basic"); @(negedge clk);
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "under"); @(negedge clk);
        op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "equal"); @(negedge clk);
        op8(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, "msb");   @(negedge clk);

        // start held with other operands through RUN and DONE
        op8(8'h5A, 8'h3C, 1'b1, 8'h1E, 1'b0, "ign");
        @(negedge clk);
        chk("ign_idle_gap", longint'(busy8), 0);
        op8(8'h11, 8'h22, 1'b0, 8'hEF, 1'b1, "ign_next"); @(negedge clk);

        op1(1'b0, 1'b0, 1'b0, 1'b0, "w1_00");
        op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");
        op1(1'b0, 1'b1, 1'b1, 1'b1, "w1_01");
        op1(1'b1, 1'b1, 1'b0, 1'b0, "w1_11");

        // Continuous start with operands changing every cycle
        st8 = 1'b1;
        repeat (60) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        st8 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset three cycles into RUN
        st8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
        @(negedge clk); st8 = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", longint'(busy8), 0);
        chk("arst_done", longint'(done8), 0);
        chk("arst_diff", longint'(diff8), 0);
        chk("arst_bo",   longint'(bo8), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "post_rst"); @(negedge clk);

        // Random traffic on both instances, checked by the model each cycle
        repeat (400) begin
            @(negedge clk);
            st8 = ($urandom_range(3) == 0);
            a8  = 8'($urandom); b8 = 8'($urandom);
            st1 = ($urandom_range(2) == 0);
            a1  = 1'($urandom); b1 = 1'($urandom);
        end
        st8 = 1'b0; st1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Sequencing controller that performs an N-bit subtraction, diff = a − b, one bit per clock on a single 1-bit subtractor cell with a registered borrow. The cell is a half-subtractor pair with borrow chaining. The block accepts operands with a start/busy/done handshake and holds the result until the next operation. It sits beside the existing half-subtractor datapath as the block that sequences it across multi-bit operands.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepting edge only
- b  input  WIDTH  subtrahend; captured on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; diff and bo are valid
- diff  output  WIDTH  difference a − b mod 2^WIDTH
- bo  output  1  final borrow; 1 iff a < b, unsigned

## Operation
- **States.** IDLE, RUN, DONE; encoding is free.
- **Reset (rst_n low).** State goes to IDLE immediately, asynchronously.
  - busy = 0, done = 0, diff = 0, bo = 0.
  - Operand shift registers, borrow register and bit counter are all cleared.
- **IDLE.** If start = 1 at the edge:
  - Capture a and b into shift registers.
  - Clear the borrow register, clear diff, and set the bit counter to 0.
  - Go to RUN. Otherwise stay in IDLE.
- **RUN, each edge.**
  - Bit slice: x = a_sr[0], y = b_sr[0], br = borrow register.
  - Difference bit = x ^ y ^ br.
  - Next borrow = (~x & y) | (~(x ^ y) & br).
  - Shift the difference bit into diff at the MSB, shifting right, so after WIDTH shifts bit i sits at diff[i].
  - Shift a_sr and b_sr right by one.
  - Increment the counter.
  - On the edge where the counter reaches WIDTH−1: load bo from the next-borrow value and go to DONE.
- **DONE.** done = 1 for exactly this cycle; go to IDLE on the next edge.
- **start handling.** start is ignored in RUN and DONE; no queuing.
- **Operand stability.** a and b may change freely after the accepting edge.
- **Result hold.** diff and bo hold their values from DONE until the next accepting edge clears diff.
- **Arithmetic.** Unsigned. diff equals (a − b) mod 2^WIDTH; bo is the borrow out of the MSB.
- **Counter.** Width $clog2(WIDTH) with a minimum of 1 bit.
- **WIDTH = 1.** RUN lasts exactly one cycle.

## Timing
- **Accepting edge.** Edge E0, with start = 1 and state IDLE.
- **Busy window.** busy is high from after E0 through the edge E_WIDTH, i.e. exactly WIDTH cycles.
- **Done.** High in the cycle after E_WIDTH; diff and bo are final in that same cycle.
- **Back-to-back.** The earliest next accept is the edge after the DONE cycle (E_WIDTH+2). Sustained throughput is one operation per WIDTH+2 cycles when start is held high.
- **Outputs.** All are registered; no combinational path from start, a or b to any output.
- **Reset mid-operation.** Asserting rst_n in RUN or DONE aborts the operation.
  - done never pulses for the aborted operation.
  - All outputs read 0 while reset is asserted.
- **After reset.** The first accept is possible on the first rising edge after rst_n deasserts.

## Test plan
- **Basic subtract.** WIDTH=8, a=0x5A, b=0x3C, start pulse → busy high 8 cycles; done pulses on the 9th cycle after accept with diff=0x1E, bo=0.
- **Underflow and equal operands.**
  - a=0x00, b=0x01 → diff=0xFF, bo=1.
  - a=0xFF, b=0xFF → diff=0x00, bo=0.
  - a=0x80, b=0x7F → diff=0x01, bo=0.
- **start ignored while busy.** Re-assert start with a=0x11, b=0x22 during RUN and during DONE → no restart; result is that of the first operation; an IDLE cycle precedes the next accept.
- **Continuous start.** Hold start high with operands changing every cycle → accepts every 10 cycles. Each result matches the operands present on its accepting edge; a and b are changed mid-RUN with no effect.
- **Reset mid-RUN.** Assert rst_n low 3 cycles after accept → busy, done, diff, bo go to 0 asynchronously. No done pulse. A new op with 0x10 − 0x01 after release gives diff=0x0F.
- **WIDTH=1.** Drive all four a/b combinations → diff/bo = 0/0, 1/0, 1/1, 0/0 for (a,b) = (0,0), (1,0), (0,1), (1,1); done appears 1 cycle after the busy cycle.
